// File: rtl/out_pkg.sv
// Shared constants and output FSM encoding for output_streamer.
// Used by the ASCII text formatter when OUTPUT_ASCII_EN is defined.
package out_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEP,
    ST_DIG,
    ST_NL,
    ST_FIN
  } out_state_t;

  function automatic logic [7:0] digit_char(input logic [2:0] d);
    return ASCII_ZERO + {5'b0, d};
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO of 3-bit digits; caller never pushes when full
// without a same-cycle pop and never pops when empty.
module out_fifo
  import out_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [2:0]               wdata,
  output logic [2:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/output_streamer.sv
// Buffers execute-stage digits and streams them to the host as bytes.
// OUTPUT_ASCII_EN selects comma-separated text with a trailing LF.
module output_streamer
  import out_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       reg_out,
  input  logic             out_valid,
  input  logic             halt,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_byte_valid,
  output logic             done,
  output logic             overflow,
  output logic [LVL_W-1:0] fifo_level
);

  logic       halt_seen;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [2:0] rdata;
  logic [7:0] byte_d;
  logic       obv_d;
  logic       done_cond;

  // halt_seen is registered, so the cycle halt rises still pushes
  assign push_req = out_valid && !halt_seen;
  assign push     = push_req && (!full || pop);

  out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (reg_out),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef OUTPUT_ASCII_EN
  out_state_t state_q;
  out_state_t state_d;
  logic       first_q;
  logic       first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    byte_d  = out_byte;
    obv_d   = out_byte_valid;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          obv_d = 1'b1;
          if (first_q) begin
            byte_d  = digit_char(rdata);
            pop     = 1'b1;
            first_d = 1'b0;
            state_d = ST_DIG;
          end else begin
            byte_d  = ASCII_COMMA;
            state_d = ST_SEP;
          end
        end else if (halt_seen) begin
          byte_d  = ASCII_LF;
          obv_d   = 1'b1;
          state_d = ST_NL;
        end
      end
      ST_SEP: begin
        if (out_ready) begin
          byte_d  = digit_char(rdata);
          pop     = 1'b1;
          state_d = ST_DIG;
        end
      end
      ST_DIG: begin
        if (out_ready) begin
          obv_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_NL: begin
        if (out_ready) begin
          obv_d   = 1'b0;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_cond = halt_seen && empty && !out_byte_valid
                  && (state_q == ST_FIN);
`else
  always_comb begin
    byte_d = out_byte;
    obv_d  = out_byte_valid;
    pop    = 1'b0;
    if (!out_byte_valid || out_ready) begin
      obv_d = !empty;
      if (!empty) begin
        byte_d = {5'b0, rdata};
        pop    = 1'b1;
      end
    end
  end

  assign done_cond = halt_seen && empty && !out_byte_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_seen      <= 1'b0;
      overflow       <= 1'b0;
      out_byte       <= '0;
      out_byte_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      halt_seen      <= halt_seen | halt;
      overflow       <= overflow | (push_req && full && !pop);
      out_byte       <= byte_d;
      out_byte_valid <= obv_d;
      done           <= done | done_cond;
    end
  end

endmodule

// File: tb/tb_output_streamer.sv
// Directed self-checking bench for output_streamer.
// Raw-mode checks by default; ASCII checks when OUTPUT_ASCII_EN is set.
module tb_output_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] reg_out = '0;
  logic       out_valid = 1'b0;
  logic       halt = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic       out_byte_valid;
  logic       done;
  logic       overflow;
  logic [3:0] fifo_level;

  int n_chk = 0;
  int n_fail = 0;
  int rel [8] = '{3, 4, 5, 6, 7, 0, 1, 3};
  int asc [6] = '{32'h32, 32'h2C, 32'h34, 32'h2C, 32'h31, 32'h0A};
  logic [7:0] q [$];

  output_streamer #(
    .DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_out        (reg_out),
    .out_valid      (out_valid),
    .halt           (halt),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid),
    .done           (done),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_valid = 1'b0;
    halt = 1'b0;
    out_ready = 1'b0;
    reg_out = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic collect(input int budget);
    q.delete();
    for (int i = 0; i < budget; i++) begin
      if (out_byte_valid && out_ready) q.push_back(out_byte);
      if (done) break;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0] last_b;
    #2;
    check("rst_byte", 32'(out_byte), 0);
    check("rst_obv", 32'(out_byte_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_lvl", 32'(fifo_level), 0);
    do_reset();

`ifndef OUTPUT_ASCII_EN
    // Digits 4, 6, 3 with ready high, then halt
    out_ready = 1'b1;
    out_valid = 1'b1; reg_out = 3'd4;
    step();
    out_valid = 1'b0;
    check("t1_lvl1", 32'(fifo_level), 1);
    check("t1_obv0", 32'(out_byte_valid), 0);
    step();
    check("t1_obv4", 32'(out_byte_valid), 1);
    check("t1_b4", 32'(out_byte), 32'h04);
    out_valid = 1'b1; reg_out = 3'd6;
    step();
    out_valid = 1'b0;
    step();
    check("t1_b6", 32'(out_byte), 32'h06);
    out_valid = 1'b1; reg_out = 3'd3;
    step();
    out_valid = 1'b0; halt = 1'b1;
    step();
    check("t1_b3", 32'(out_byte), 32'h03);
    check("t1_ndone", 32'(done), 0);
    for (int i = 0; i < 5 && !done; i++) step();
    check("t1_done", 32'(done), 1);
    check("t1_obvend", 32'(out_byte_valid), 0);
    step();
    check("t1_sticky", 32'(done), 1);

    // Fill register + FIFO under backpressure, then push while popping
    do_reset();
    for (int i = 0; i < 9; i++) begin
      out_valid = 1'b1;
      reg_out = 3'((i + 1) % 8);
      step();
      if (i == 4) check("t2_hold", 32'(out_byte), 32'h01);
    end
    out_valid = 1'b0;
    check("t2_lvl8", 32'(fifo_level), 8);
    check("t2_noovf", 32'(overflow), 0);
    check("t2_b1", 32'(out_byte), 32'h01);
    out_ready = 1'b1; out_valid = 1'b1; reg_out = 3'd3;
    step();
    out_ready = 1'b0; reg_out = 3'd6;
    check("t4_lvl", 32'(fifo_level), 8);
    check("t4_noovf", 32'(overflow), 0);
    check("t4_b2", 32'(out_byte), 32'h02);
    step();
    out_valid = 1'b0;
    check("t2_ovf", 32'(overflow), 1);
    check("t2_lvlf", 32'(fifo_level), 8);
    check("t2_stable", 32'(out_byte), 32'h02);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("t2_rel%0d", k), 32'(out_byte), 32'(rel[k]));
    end
    step();
    check("t2_obv0", 32'(out_byte_valid), 0);
    check("t2_lvl0", 32'(fifo_level), 0);

    // Last digit coincides with halt; out_valid stays high afterwards
    do_reset();
    out_ready = 1'b1;
    out_valid = 1'b1; reg_out = 3'd5; halt = 1'b1;
    cnt = 0;
    last_b = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_byte_valid) begin
        cnt++;
        last_b = out_byte;
      end
    end
    check("t3_cnt", 32'(cnt), 1);
    check("t3_byte", 32'(last_b), 32'h05);
    check("t3_done", 32'(done), 1);
    out_valid = 1'b0; halt = 1'b0;
`else
    // Digits 2, 4, 1 then halt
    out_valid = 1'b1; reg_out = 3'd2; step();
    out_valid = 1'b0; step();
    out_valid = 1'b1; reg_out = 3'd4; step();
    out_valid = 1'b0; step();
    out_valid = 1'b1; reg_out = 3'd1; step();
    out_valid = 1'b0; halt = 1'b1; step();
    step();
    check("a1_first", 32'(out_byte), 32'h32);
    out_ready = 1'b1;
    collect(60);
    check("a1_done", 32'(done), 1);
    check("a1_len", 32'(q.size()), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("a1_c%0d", k),
            (k < q.size()) ? 32'(q[k]) : 32'hFFFF, 32'(asc[k]));
    end

    // Halt with no digits emits a lone LF
    do_reset();
    halt = 1'b1; out_ready = 1'b1;
    collect(20);
    check("a2_done", 32'(done), 1);
    check("a2_len", 32'(q.size()), 1);
    check("a2_lf", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF, 32'h0A);
    halt = 1'b0;
`endif

    // Asynchronous reset while buffered data is waiting
    do_reset();
    for (int i = 0; i < 6; i++) begin
      out_valid = 1'b1;
      reg_out = 3'(i + 1);
      step();
    end
    out_valid = 1'b0;
    check("t6_lvl5", 32'(fifo_level), 5);
    check("t6_obv", 32'(out_byte_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rbyte", 32'(out_byte), 0);
    check("t6_robv", 32'(out_byte_valid), 0);
    check("t6_rlvl", 32'(fifo_level), 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_byte_valid) cnt++;
    end
    check("t6_stale", 32'(cnt), 0);
    check("t6_lvl0", 32'(fifo_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
